afu_mem_responder: RTL

- Host-memory responder model for the AFU request/response interface.
- Services cache-line read and write requests from an AFU user block (e.g. afu_user_2) against an internal line-addressed memory.
- Read data and write completions are returned on the rd_rsp / wr_rsp0 / wr_rsp1 channels.
- Used as the far end of the interface in standalone AFU simulation and loopback tests.

---
 rtl/afu_mem_responder.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/afu_mem_responder.sv
// Host-memory responder for the AFU request/response interface: two request FIFOs
// feeding a line-addressed memory, with a fixed-latency read pipe and split write completions.
module afu_mem_responder #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int MEM_AW      = 10,
  parameter int RQ_DEPTH    = 8,
  parameter int AF_SLACK    = 2,
  parameter int RD_LAT      = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_LMT-1:0]    rd_req_addr,
  input  logic [MDATA-1:0]       rd_req_mdata,
  input  logic                   rd_req_en,
  output logic                   rd_req_almostfull,
  output logic                   rd_rsp_valid,
  output logic [MDATA-1:0]       rd_rsp_mdata,
  output logic [CACHE_WIDTH-1:0] rd_rsp_data,
  input  logic [ADDR_LMT-1:0]    wr_req_addr,
  input  logic [MDATA-1:0]       wr_req_mdata,
  input  logic [CACHE_WIDTH-1:0] wr_req_data,
  input  logic                   wr_req_en,
  output logic                   wr_req_almostfull,
  output logic                   wr_rsp0_valid,
  output logic [MDATA-1:0]       wr_rsp0_mdata,
  output logic                   wr_rsp1_valid,
  output logic [MDATA-1:0]       wr_rsp1_mdata,
  input  logic                   svc_stall,
  output logic                   ovf_err,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count
);

  // Handshake: *_req_en is a fire-and-forget valid beat with no ready; almostfull is
  // only a hint, and a beat arriving while its FIFO is full is lost and flagged in
  // ovf_err. Responses are single-cycle valid pulses with no backpressure.

  localparam int PW = $clog2(RQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] AF_TH    = CW'(RQ_DEPTH - AF_SLACK);
  localparam logic [CW-1:0] FULL_CNT = CW'(RQ_DEPTH);

  // Read request FIFO
  logic [MEM_AW-1:0] rq_idx_q   [RQ_DEPTH];
  logic [MDATA-1:0]  rq_mdata_q [RQ_DEPTH];
  logic [PW-1:0]     rq_wp_q, rq_rp_q;
  logic [CW-1:0]     rq_cnt_q, rq_cnt_d;
  logic              rq_full, rq_push, rq_pop;

  assign rq_full = (rq_cnt_q == FULL_CNT);
  assign rq_push = rd_req_en && !rq_full;
  assign rq_pop  = reset_n && !svc_stall && (rq_cnt_q != '0);

  always_comb begin
    rq_cnt_d = rq_cnt_q;
    case ({rq_push, rq_pop})
      2'b10:   rq_cnt_d = rq_cnt_q + CW'(1);
      2'b01:   rq_cnt_d = rq_cnt_q - CW'(1);
      default: rq_cnt_d = rq_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rq_wp_q  <= '0;
      rq_rp_q  <= '0;
      rq_cnt_q <= '0;
    end else begin
      if (rq_push) rq_wp_q <= rq_wp_q + PW'(1);
      if (rq_pop)  rq_rp_q <= rq_rp_q + PW'(1);
      rq_cnt_q <= rq_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_idx_q[rq_wp_q]   <= rd_req_addr[MEM_AW-1:0];
      rq_mdata_q[rq_wp_q] <= rd_req_mdata;
    end
  end

  // Write request FIFO
  logic [MEM_AW-1:0]      wq_idx_q   [RQ_DEPTH];
  logic [MDATA-1:0]       wq_mdata_q [RQ_DEPTH];
  logic [CACHE_WIDTH-1:0] wq_data_q  [RQ_DEPTH];
  logic [PW-1:0]          wq_wp_q, wq_rp_q;
  logic [CW-1:0]          wq_cnt_q, wq_cnt_d;
  logic                   wq_full, wq_push, wq_pop;

  assign wq_full = (wq_cnt_q == FULL_CNT);
  assign wq_push = wr_req_en && !wq_full;
  assign wq_pop  = reset_n && !svc_stall && (wq_cnt_q != '0);

  always_comb begin
    wq_cnt_d = wq_cnt_q;
    case ({wq_push, wq_pop})
      2'b10:   wq_cnt_d = wq_cnt_q + CW'(1);
      2'b01:   wq_cnt_d = wq_cnt_q - CW'(1);
      default: wq_cnt_d = wq_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wq_wp_q  <= '0;
      wq_rp_q  <= '0;
      wq_cnt_q <= '0;
    end else begin
      if (wq_push) wq_wp_q <= wq_wp_q + PW'(1);
      if (wq_pop)  wq_rp_q <= wq_rp_q + PW'(1);
      wq_cnt_q <= wq_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wq_push) begin
      wq_idx_q[wq_wp_q]   <= wr_req_addr[MEM_AW-1:0];
      wq_mdata_q[wq_wp_q] <= wr_req_mdata;
      wq_data_q[wq_wp_q]  <= wr_req_data;
    end
  end

  assign rd_req_almostfull = (rq_cnt_q >= AF_TH);
  assign wr_req_almostfull = (wq_cnt_q >= AF_TH);

  // Upper address bits alias onto the same line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_req_addr[ADDR_LMT-1:MEM_AW], wr_req_addr[ADDR_LMT-1:MEM_AW]};

  // Line memory, not reset. Write and pipe-entry read share the pop edge, so a
  // same-index read sees the old line.
  logic [CACHE_WIDTH-1:0] mem_q [2**MEM_AW];
  logic [MEM_AW-1:0]      w_idx;
  logic [MEM_AW-1:0]      r_idx;

  assign w_idx = wq_idx_q[wq_rp_q];
  assign r_idx = rq_idx_q[rq_rp_q];

  always_ff @(posedge clk) begin
    if (wq_pop) mem_q[w_idx] <= wq_data_q[wq_rp_q];
  end

  // Read pipe: stage 0 loads at the pop edge, last stage drives the outputs.
  logic [RD_LAT-1:0]      rp_valid_q;
  logic [MDATA-1:0]       rp_mdata_q [RD_LAT];
  logic [CACHE_WIDTH-1:0] rp_data_q  [RD_LAT];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rp_valid_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        rp_mdata_q[i] <= '0;
        rp_data_q[i]  <= '0;
      end
    end else begin
      rp_valid_q[0] <= rq_pop;
      if (rq_pop) begin
        rp_mdata_q[0] <= rq_mdata_q[rq_rp_q];
        rp_data_q[0]  <= mem_q[r_idx];
      end
      for (int i = 1; i < RD_LAT; i++) begin
        rp_valid_q[i] <= rp_valid_q[i-1];
        if (rp_valid_q[i-1]) begin
          rp_mdata_q[i] <= rp_mdata_q[i-1];
          rp_data_q[i]  <= rp_data_q[i-1];
        end
      end
    end
  end

  assign rd_rsp_valid = rp_valid_q[RD_LAT-1];
  assign rd_rsp_mdata = rp_mdata_q[RD_LAT-1];
  assign rd_rsp_data  = rp_data_q[RD_LAT-1];

  // Write completions, steered by line parity.
  logic             w0_valid_q, w1_valid_q;
  logic [MDATA-1:0] w0_mdata_q, w1_mdata_q;
  logic             w_odd;

  assign w_odd = w_idx[0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w0_valid_q <= 1'b0;
      w1_valid_q <= 1'b0;
      w0_mdata_q <= '0;
      w1_mdata_q <= '0;
    end else begin
      w0_valid_q <= wq_pop && !w_odd;
      w1_valid_q <= wq_pop && w_odd;
      if (wq_pop && !w_odd) w0_mdata_q <= wq_mdata_q[wq_rp_q];
      if (wq_pop && w_odd)  w1_mdata_q <= wq_mdata_q[wq_rp_q];
    end
  end

  assign wr_rsp0_valid = w0_valid_q;
  assign wr_rsp0_mdata = w0_mdata_q;
  assign wr_rsp1_valid = w1_valid_q;
  assign wr_rsp1_mdata = w1_mdata_q;

  // Sticky overflow flag and response counters (counted as each pulse retires).
  logic        ovf_q;
  logic [31:0] rd_count_q, wr_count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q      <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if ((rd_req_en && rq_full) || (wr_req_en && wq_full)) ovf_q <= 1'b1;
      if (rd_rsp_valid) rd_count_q <= rd_count_q + 32'd1;
      if (w0_valid_q || w1_valid_q) wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign ovf_err  = ovf_q;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule
